// File: rtl/exibidor_pkg.sv
// Shared encodings, default timings and helpers for the LED sequence player.
// The optional off-gap phase is enabled with the EXIBIDOR_APAGADO_EN macro.
package exibidor_pkg;

  localparam int unsigned T_ACESO_DEF   = 1000;
  localparam int unsigned T_APAGADO_DEF = 500;
  localparam int unsigned EST_W         = 4;

  localparam logic [EST_W-1:0] ST_INICIAL = 4'd0;
  localparam logic [EST_W-1:0] ST_LE_MEM  = 4'd1;
  localparam logic [EST_W-1:0] ST_ACESO   = 4'd2;
  localparam logic [EST_W-1:0] ST_APAGADO = 4'd3;
  localparam logic [EST_W-1:0] ST_FIM     = 4'd4;

  typedef enum logic [EST_W-1:0] {
    INICIAL = ST_INICIAL,
    LE_MEM  = ST_LE_MEM,
    ACESO   = ST_ACESO,
    APAGADO = ST_APAGADO,
    FIM     = ST_FIM
  } estado_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/exibidor_sequencia_temporizador.sv
// Down-counting phase timer: load N-1 on state entry, fim flags the last cycle.
module temporizador #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] valor,
  input  logic         carregar,
  input  logic         habilitar,
  output logic         fim
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carregar) begin
      cnt_d = valor;
    end else if (habilitar && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // fim is registered from the next count so it is valid in the first cycle of a phase
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      fim   <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      fim   <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/exibidor_sequencia.sv
// Plays ROM items 0..limite on the LEDs, each lit T_ACESO cycles, then pulses pronto.
// With EXIBIDOR_APAGADO_EN defined, each item is followed by a T_APAGADO dark gap.
module exibidor_sequencia
  import exibidor_pkg::*;
#(
  parameter int unsigned T_ACESO   = T_ACESO_DEF,
  parameter int unsigned T_APAGADO = T_APAGADO_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int unsigned TW = $clog2(max_u(T_ACESO, T_APAGADO) + 1);

  estado_t    estado_q, estado_d;
  logic [3:0] endereco_q, endereco_d;
  logic [3:0] limite_q, limite_d;
  logic       exibindo_q, pronto_q;
  logic       avancar;

  logic [TW-1:0] tmr_valor;
  logic          tmr_carregar;
  logic          tmr_habilitar;
  logic          tmr_fim;

  temporizador #(.W(TW)) u_temporizador (
    .clock     (clock),
    .reset     (reset),
    .valor     (tmr_valor),
    .carregar  (tmr_carregar),
    .habilitar (tmr_habilitar),
    .fim       (tmr_fim)
  );

  // Next-state, address and latched-limit logic
  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    avancar    = 1'b0;
    unique case (estado_q)
      INICIAL: begin
        if (iniciar) begin
          estado_d   = LE_MEM;
          endereco_d = '0;
          limite_d   = limite;
        end
      end
      LE_MEM: estado_d = ACESO;
      ACESO: begin
        if (tmr_fim) begin
`ifdef EXIBIDOR_APAGADO_EN
          estado_d = APAGADO;
`else
          avancar  = 1'b1;
`endif
        end
      end
      APAGADO: begin
        if (tmr_fim) avancar = 1'b1;
      end
      FIM: begin
        estado_d   = INICIAL;
        endereco_d = '0;
      end
      default: begin
        estado_d   = INICIAL;
        endereco_d = '0;
      end
    endcase
    // End of an item: stop at the latched limit, never wrap the address
    if (avancar) begin
      if (endereco_q == limite_q) begin
        estado_d = FIM;
      end else begin
        endereco_d = endereco_q + 4'd1;
        estado_d   = LE_MEM;
      end
    end
  end

  // Timer reloads on every state change with the duration of the state being entered
  always_comb begin
    tmr_carregar  = (estado_d != estado_q);
    tmr_habilitar = (estado_q == ACESO) || (estado_q == APAGADO);
    tmr_valor     = '0;
    case (estado_d)
      ACESO:   tmr_valor = TW'(T_ACESO - 1);
      APAGADO: tmr_valor = TW'(T_APAGADO - 1);
      default: tmr_valor = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q   <= INICIAL;
      endereco_q <= '0;
      limite_q   <= '0;
      exibindo_q <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      exibindo_q <= (estado_d != INICIAL);
      pronto_q   <= (estado_d == FIM);
    end
  end

  // ROM data arrives one cycle after the address, so leds pass it straight through in ACESO
  assign leds      = (estado_q == ACESO) ? dado_memoria : 4'b0000;
  assign endereco  = endereco_q;
  assign exibindo  = exibindo_q;
  assign pronto    = pronto_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Scoreboard bench for exibidor_sequencia: stimulus queues expected items/pronto, a monitor checks them.
module tb_exibidor_sequencia;
  import exibidor_pkg::*;

  localparam int TA = 4;
  localparam int TP = 2;
`ifdef EXIBIDOR_APAGADO_EN
  localparam int TOFF = TP;
`else
  localparam int TOFF = 0;
`endif
  localparam int P = 1 + TA + TOFF;

  typedef struct {
    int dado;
    int addr;
    int inicio;
  } item_t;

  item_t exp_items[$];
  int    exp_pronto[$];

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [3:0] dado_memoria = 4'd0;
  logic [3:0] endereco, leds, db_estado;
  logic       exibindo, pronto;
  logic [3:0] rom [16];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int busy_s = 1;
  int busy_e = 0;

  exibidor_sequencia #(.T_ACESO(TA), .T_APAGADO(TP)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .limite       (limite),
    .dado_memoria (dado_memoria),
    .endereco     (endereco),
    .leds         (leds),
    .exibindo     (exibindo),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous 16x4 ROM with one-cycle read latency
  always @(posedge clock) dado_memoria <= rom[endereco];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: new item = leds rising from 0 (ROM holds only nonzero data)
  item_t      it;
  int         run_len = 0;
  int         cur_dado = 0;
  logic [3:0] prev_leds = 4'd0;

  always @(negedge clock) begin
    if (reset) begin
      if (leds != 4'd0 && prev_leds == 4'd0) begin
        if (exp_items.size() == 0) begin
          chk("item_unexpected", int'(leds), 0);
        end else begin
          it = exp_items.pop_front();
          chk("item_start_cycle", cyc, it.inicio);
          chk("item_data", int'(leds), it.dado);
          chk("item_address", int'(endereco), it.addr);
          cur_dado = it.dado;
        end
        run_len = 1;
      end else if (leds != 4'd0) begin
        run_len++;
        chk("item_stable", int'(leds), cur_dado);
      end else if (prev_leds != 4'd0) begin
        chk("item_duration", run_len, TA);
      end
      if (pronto) begin
        if (exp_pronto.size() == 0) chk("pronto_unexpected", 1, 0);
        else chk("pronto_cycle", cyc, exp_pronto.pop_front());
      end
      chk("exibindo", int'(exibindo), (cyc >= busy_s && cyc <= busy_e) ? 1 : 0);
    end
    prev_leds = leds;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(1, 15));
  endtask

  // Reference model: run accepted in cycle n with limit lim
  task automatic push_run(input int n, input int lim, output int p);
    for (int k = 0; k <= lim; k++) exp_items.push_back('{int'(rom[k]), k, n + 2 + k * P});
    p = n + 1 + (lim + 1) * P;
    exp_pronto.push_back(p);
    busy_s = n + 1;
    busy_e = p;
  endtask

  task automatic start(input int lim, output int n, output int p);
    iniciar = 1'b1;
    limite  = 4'(lim);
    n = cyc;
    push_run(n, lim, p);
    tick();
    iniciar = 1'b0;
    limite  = 4'($urandom_range(0, 15));
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_leds"}, int'(leds), 0);
    chk({nm, "_endereco"}, int'(endereco), 0);
    chk({nm, "_exibindo"}, int'(exibindo), 0);
    chk({nm, "_pronto"}, int'(pronto), 0);
    chk({nm, "_db_estado"}, int'(db_estado), int'(ST_INICIAL));
  endtask

  initial begin
    int n, p, p2;
    fill_rom();

    // Reset state while held and after release
    repeat (3) tick();
    chk_idle("reset_held");
    reset = 1'b1;
    tick();
    chk_idle("reset_release");

    // Single item, start at cycle 10
    wait_cycle(10);
    start(0, n, p);
    wait_cycle(p + 1);

    // Four items with one-hot data, then idle
    rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4; rom[3] = 4'd8;
    tick();
    start(3, n, p);
    wait_cycle(p + 1);
    chk("after_run_exibindo", int'(exibindo), 0);

    // Full 16-item run, address must stop at 15
    fill_rom();
    tick();
    start(15, n, p);
    wait_cycle(p + 1);
    chk("full_run_pronto_offset", p - n, 1 + 16 * P);

    // Re-pulse iniciar with a new limite mid-run: must be ignored
    fill_rom();
    tick();
    start(3, n, p);
    wait_cycle(n + 2 + P + 1);
    iniciar = 1'b1;
    limite  = 4'd15;
    repeat (3) tick();
    iniciar = 1'b0;
    wait_cycle(p + 1);

    // iniciar held high through FIM starts a new run in the following INICIAL cycle
    fill_rom();
    tick();
    start(2, n, p);
    wait_cycle(p);
    iniciar = 1'b1;
    limite  = 4'd1;
    tick();
    push_run(cyc, 1, p2);
    tick();
    iniciar = 1'b0;
    wait_cycle(p2 + 1);

    // Reset during ACESO of item 2, then restart from address 0
    fill_rom();
    tick();
    start(5, n, p);
    wait_cycle(n + 2 + 2 * P + 1);
    reset = 1'b0;
    exp_items.delete();
    exp_pronto.delete();
    busy_e = 0;
    tick();
    chk_idle("midrun_reset");
    tick();
    reset = 1'b1;
    tick();
    chk_idle("midrun_release");
    start(2, n, p);
    wait_cycle(p + 1);

    // Randomized runs
    repeat (6) begin
      fill_rom();
      repeat ($urandom_range(1, 5)) tick();
      start($urandom_range(0, 15), n, p);
      wait_cycle(p + 1);
    end

    repeat (4) tick();
    chk("items_outstanding", exp_items.size(), 0);
    chk("pronto_outstanding", exp_pronto.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
